// File: rtl/chip8_regfile_seq.sv
// CHIP-8 register file (V0..VF) with a sequencer for block transfers
// between the registers and memory.
// Two write ports, a dedicated flag-register write port and three
// combinational read ports. A burst engine walks V0..Vlast issuing
// one memory request per register: a store sends register data, a load
// writes the returned data back.
// Optional feature: define CHIP8_REGFILE_RESET_CLEAR_EN to clear every
// register on reset. When it is undefined the register array has no
// reset, so it can map onto RAM.
module chip8_regfile_seq #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              cpu_clk,
  input  logic              reset,
  input  logic [AW-1:0]     addr1,
  input  logic [AW-1:0]     addr2,
  input  logic [DATA_W-1:0] writedata1,
  input  logic [DATA_W-1:0] writedata2,
  input  logic              WE1,
  input  logic              WE2,
  input  logic [DATA_W-1:0] VFwritedata,
  input  logic              WEVF,
  output logic [DATA_W-1:0] readdata1,
  output logic [DATA_W-1:0] readdata2,
  output logic [DATA_W-1:0] VFreaddata,
  input  logic              burst_start,
  input  logic              burst_dir,
  input  logic [AW-1:0]     burst_last,
  output logic              burst_busy,
  output logic              burst_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_index,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  localparam logic [AW-1:0] VF_IDX = AW'(NUM_REGS - 1);

  state_t              r_state;
  state_t              w_next;
  logic                r_dir;
  logic [AW-1:0]       r_last;
  logic [AW-1:0]       r_idx;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic                w_busy;
  logic                w_xfer;
  logic                w_load_we;
  logic                w_we [NUM_REGS];
  logic [DATA_W-1:0]   w_wd [NUM_REGS];

  assign w_busy    = (r_state != S_IDLE);
  assign w_xfer    = (r_state == S_REQ) && mem_ack;
  assign w_load_we = w_xfer && r_dir;

  // Reads are straight array lookups; a same-edge write is not forwarded.
  assign readdata1  = r_regs[addr1];
  assign readdata2  = r_regs[addr2];
  assign VFreaddata = r_regs[VF_IDX];
  assign mem_wdata  = r_regs[mem_index];

  // FSM state register; reset drops any burst in flight.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // FSM next state: one request per register until the last one is acked.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (burst_start) w_next = S_REQ;
      S_REQ:   if (mem_ack && (r_idx == r_last)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // FSM outputs: request qualifiers, busy and the completion pulse.
  always_comb begin
    burst_busy = 1'b0;
    burst_done = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_index  = '0;
    case (r_state)
      S_REQ: begin
        burst_busy = 1'b1;
        mem_req    = 1'b1;
        mem_we     = ~r_dir;
        mem_index  = r_idx;
      end
      S_DONE: begin
        burst_busy = 1'b1;
        burst_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Burst context: direction and end index latched at start, index
  // advanced on each ack. Termination at r_last keeps the index in range.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      r_dir  <= 1'b0;
      r_last <= '0;
      r_idx  <= '0;
    end else if ((r_state == S_IDLE) && burst_start) begin
      r_dir  <= burst_dir;
      r_last <= burst_last;
      r_idx  <= '0;
    end else if (w_xfer && (r_idx != r_last)) begin
      r_idx  <= r_idx + AW'(1);
    end
  end

  // Per-register write select, lowest priority first so later terms win:
  // WE1 < WE2 < WEVF < burst load. Host ports are locked out while busy.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      w_we[i] = 1'b0;
      w_wd[i] = '0;
      if (!w_busy) begin
        if (WE1 && (addr1 == AW'(i))) begin
          w_we[i] = 1'b1;
          w_wd[i] = writedata1;
        end
        if (WE2 && (addr2 == AW'(i))) begin
          w_we[i] = 1'b1;
          w_wd[i] = writedata2;
        end
        if (WEVF && (VF_IDX == AW'(i))) begin
          w_we[i] = 1'b1;
          w_wd[i] = VFwritedata;
        end
      end
      if (w_load_we && (r_idx == AW'(i))) begin
        w_we[i] = 1'b1;
        w_wd[i] = mem_rdata;
      end
    end
  end

`ifdef CHIP8_REGFILE_RESET_CLEAR_EN
  // Register array with reset clear.
  always_ff @(posedge cpu_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_we[i]) r_regs[i] <= w_wd[i];
      end
    end
  end
`else
  // Register array without reset; contents survive reset.
  always_ff @(posedge cpu_clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_we[i]) r_regs[i] <= w_wd[i];
    end
  end
`endif

endmodule

// File: tb/tb_chip8_regfile_seq.sv
// Bench for chip8_regfile_seq: directed stimulus with a scoreboard of
// expected memory transactions and done pulses, drained by a monitor.
module tb_chip8_regfile_seq;

  logic       cpu_clk = 1'b0;
  logic       reset;
  logic [3:0] addr1, addr2;
  logic [7:0] writedata1, writedata2, VFwritedata;
  logic       WE1, WE2, WEVF;
  logic [7:0] readdata1, readdata2, VFreaddata;
  logic       burst_start, burst_dir;
  logic [3:0] burst_last;
  logic       burst_busy, burst_done, mem_req, mem_we;
  logic [3:0] mem_index;
  logic [7:0] mem_wdata;
  logic       mem_ack = 1'b0;
  logic [7:0] mem_rdata = 8'h00;

  chip8_regfile_seq #(.DATA_W(8), .NUM_REGS(16)) dut (
    .cpu_clk(cpu_clk), .reset(reset),
    .addr1(addr1), .addr2(addr2),
    .writedata1(writedata1), .writedata2(writedata2),
    .WE1(WE1), .WE2(WE2),
    .VFwritedata(VFwritedata), .WEVF(WEVF),
    .readdata1(readdata1), .readdata2(readdata2), .VFreaddata(VFreaddata),
    .burst_start(burst_start), .burst_dir(burst_dir), .burst_last(burst_last),
    .burst_busy(burst_busy), .burst_done(burst_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_index(mem_index),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    logic       we;
    logic [3:0] idx;
    logic [7:0] wd;
    int         cyc;
  } txn_t;

  txn_t       exq[$];
  int         doneq[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         stall_n = 0;
  int         scnt = 0;
  logic [7:0] mdl [16];
  txn_t       mon_t;
  int         mon_c;
  int         c0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  always @(posedge cpu_clk) cyc++;

  // Memory model: ack after stall_n wait cycles, load data = index + 0x40.
  always @(negedge cpu_clk) begin
    if (mem_req === 1'b1) begin
      if (scnt >= stall_n) begin
        mem_ack   = 1'b1;
        mem_rdata = 8'h40 + {4'h0, mem_index};
        scnt      = 0;
      end else begin
        mem_ack = 1'b0;
        scnt++;
      end
    end else begin
      mem_ack = 1'b0;
      scnt    = 0;
    end
  end

  // Monitor: pop and compare on every accepted request and every done pulse.
  always @(negedge cpu_clk) begin
    #2;
    if (mem_req === 1'b1 && mem_ack === 1'b1) begin
      if (exq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_req: got index 0x%0h expected no request", mem_index);
      end else begin
        mon_t = exq.pop_front();
        chk("mem_we", {31'd0, mem_we}, {31'd0, mon_t.we});
        chk("mem_index", {28'd0, mem_index}, {28'd0, mon_t.idx});
        chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, mon_t.wd});
        if (mon_t.cyc >= 0) chk("req_cycle", cyc, mon_t.cyc);
      end
    end
    if (burst_done === 1'b1) begin
      if (doneq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_done: got done in cycle %0d expected none", cyc);
      end else begin
        mon_c = doneq.pop_front();
        if (mon_c >= 0) chk("done_cycle", cyc, mon_c);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (burst_busy === 1'b1 && n < 300) begin
      step();
      n++;
    end
    chk("idle_timeout", {31'd0, burst_busy}, 32'd0);
  endtask

  task automatic wr1(input int a, input logic [7:0] d);
    addr1 = 4'(a); writedata1 = d; WE1 = 1'b1;
    step();
    WE1 = 1'b0;
    mdl[a] = d;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    addr1 = 0; addr2 = 0; writedata1 = 0; writedata2 = 0; VFwritedata = 0;
    WE1 = 0; WE2 = 0; WEVF = 0;
    burst_start = 0; burst_dir = 0; burst_last = 0;
    step(); step();
    // Reset state
    chk("rst_busy", {31'd0, burst_busy}, 32'd0);
    chk("rst_done", {31'd0, burst_done}, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_index", {28'd0, mem_index}, 32'd0);
`ifdef CHIP8_REGFILE_RESET_CLEAR_EN
    chk("rst_rd1", {24'd0, readdata1}, 32'd0);
    chk("rst_vf", {24'd0, VFreaddata}, 32'd0);
`endif
    reset = 1'b0;
    step();

    // Fill all registers and read them back on port 2
    for (int i = 0; i < 16; i++) wr1(i, 8'h80 + 8'(i));
    for (int i = 0; i < 16; i++) begin
      addr2 = 4'(i); #1;
      chk("fill_rd2", {24'd0, readdata2}, {24'd0, mdl[i]});
    end

    // WE1 and WE2 to the same register: WE2 wins, old value until the edge
    addr1 = 4'd3; writedata1 = 8'h5A; WE1 = 1'b1;
    addr2 = 4'd3; writedata2 = 8'hA5; WE2 = 1'b1;
    #1;
    chk("no_bypass", {24'd0, readdata1}, {24'd0, mdl[3]});
    step();
    WE1 = 1'b0; WE2 = 1'b0; mdl[3] = 8'hA5; #1;
    chk("we2_over_we1", {24'd0, readdata1}, 32'h000000A5);

    // WE2 to VF and WEVF in the same cycle: WEVF wins
    addr2 = 4'd15; writedata2 = 8'h11; WE2 = 1'b1;
    VFwritedata = 8'h01; WEVF = 1'b1;
    step();
    WE2 = 1'b0; WEVF = 1'b0; mdl[15] = 8'h01; #1;
    chk("wevf_over_we2", {24'd0, VFreaddata}, 32'h00000001);

    // WE1 to VF and WEVF in the same cycle: WEVF wins
    addr1 = 4'd15; writedata1 = 8'h22; WE1 = 1'b1;
    VFwritedata = 8'h33; WEVF = 1'b1;
    step();
    WE1 = 1'b0; WEVF = 1'b0; mdl[15] = 8'h33; #1;
    chk("wevf_over_we1", {24'd0, VFreaddata}, 32'h00000033);

    // Store burst last=2, ack tied high
    wr1(0, 8'h10); wr1(1, 8'h20); wr1(2, 8'h30);
    stall_n = 0;
    burst_dir = 1'b0; burst_last = 4'd2; burst_start = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 3; i++) exq.push_back('{1'b1, 4'(i), mdl[i], c0 + 1 + i});
    doneq.push_back(c0 + 4);
    step();
    burst_start = 1'b0;
    chk("store_busy", {31'd0, burst_busy}, 32'd1);
    wait_idle();
    chk("idle_index", {28'd0, mem_index}, 32'd0);
    chk("idle_wdata", {24'd0, mem_wdata}, 32'h00000010);
    chk("idle_req", {31'd0, mem_req}, 32'd0);

    // Load burst last=15, two stall cycles per request, host writes blocked
    stall_n = 2;
    burst_dir = 1'b1; burst_last = 4'd15; burst_start = 1'b1;
    for (int i = 0; i < 16; i++) exq.push_back('{1'b0, 4'(i), mdl[i], -1});
    doneq.push_back(-1);
    step();
    begin
      int n = 0;
      while (burst_busy === 1'b1 && n < 200) begin
        burst_start = (n == 5);
        burst_dir = 1'b0; burst_last = 4'd0;
        addr1 = 4'(n); writedata1 = 8'hEE; WE1 = 1'b1;
        VFwritedata = 8'hCC; WEVF = 1'b1;
        step();
        n++;
      end
    end
    burst_start = 1'b0; WE1 = 1'b0; WEVF = 1'b0;
    chk("load_timeout", {31'd0, burst_busy}, 32'd0);
    for (int i = 0; i < 16; i++) mdl[i] = 8'h40 + 8'(i);
    for (int i = 0; i < 16; i++) begin
      addr1 = 4'(i); #1;
      chk("load_rd1", {24'd0, readdata1}, {24'd0, mdl[i]});
    end
    chk("load_vf", {24'd0, VFreaddata}, 32'h0000004F);

    // Single-register store, last=0
    stall_n = 0;
    burst_dir = 1'b0; burst_last = 4'd0; burst_start = 1'b1;
    c0 = cyc;
    exq.push_back('{1'b1, 4'd0, mdl[0], c0 + 1});
    doneq.push_back(c0 + 2);
    step();
    burst_start = 1'b0;
    wait_idle();

    // Reset in cycle 2 of a last=5 load
    for (int i = 0; i < 6; i++) wr1(i, 8'h60 + 8'(i));
    burst_dir = 1'b1; burst_last = 4'd5; burst_start = 1'b1;
    c0 = cyc;
    exq.push_back('{1'b0, 4'd0, mdl[0], c0 + 1});
    step();
    burst_start = 1'b0;
    step();
    reset = 1'b1; #1;
    chk("midrst_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_busy", {31'd0, burst_busy}, 32'd0);
    chk("midrst_we", {31'd0, mem_we}, 32'd0);
    chk("midrst_done", {31'd0, burst_done}, 32'd0);
    step();
    reset = 1'b0;
    step(); step();
    chk("noresume_req", {31'd0, mem_req}, 32'd0);
    chk("noresume_busy", {31'd0, burst_busy}, 32'd0);
`ifdef CHIP8_REGFILE_RESET_CLEAR_EN
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
`else
    mdl[0] = 8'h40;
`endif
    for (int i = 0; i < 6; i++) begin
      addr2 = 4'(i); #1;
      chk("midrst_rd2", {24'd0, readdata2}, {24'd0, mdl[i]});
    end

    step(); step();
    chk("req_queue_drained", exq.size(), 32'd0);
    chk("done_queue_drained", doneq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chip8_regfile_seq.md
CHIP8_REGFILE_SEQ -- requirements
Module: chip8_regfile_seq

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_W, 8, register width in bits.
  NUM_REGS, 16, register count (power of two, >=2); the flag register is index NUM_REGS-1.
  AW, $clog2(NUM_REGS), address width (derived, not overridden).
REQ-002 Ports SHALL be, one per line:
  cpu_clk  in  1  sole clock; all state updates on its rising edge.
  reset  in  1  asynchronous, active-high reset.
  addr1, addr2  in  AW  read/write addresses for ports 1 and 2.
  writedata1, writedata2  in  DATA_W  write data for ports 1 and 2.
  WE1, WE2  in  1  write enables for ports 1 and 2.
  VFwritedata  in  DATA_W  flag register write data.
  WEVF  in  1  flag register write enable.
  readdata1, readdata2, VFreaddata  out  DATA_W  combinational read data.
  burst_start  in  1  one-cycle pulse starting a block transfer.
  burst_dir  in  1  0 = store V0..Vlast to memory, 1 = load V0..Vlast from memory.
  burst_last  in  AW  highest register index to transfer.
  burst_busy  out  1  high while a transfer is in progress.
  burst_done  out  1  one-cycle completion pulse.
  mem_req  out  1  memory request, held until mem_ack.
  mem_we  out  1  1 = write request, 0 = read request.
  mem_index  out  AW  register offset of the current request.
  mem_wdata  out  DATA_W  store data (= register[mem_index]).
  mem_ack  in  1  request accepted; read data valid in the same cycle.
  mem_rdata  in  DATA_W  load data.

Function
REQ-003 readdata1/readdata2 SHALL equal register[addr1]/register[addr2] combinationally; VFreaddata SHALL equal register[NUM_REGS-1]; reads return pre-edge contents (no write bypass).
REQ-004 Register writes SHALL occur on the rising edge of cpu_clk.
REQ-005 Write priority for a single register, highest first: burst load, WEVF (index NUM_REGS-1), WE2, WE1.
REQ-006 When burst_busy=1, WE1, WE2 and WEVF SHALL be ignored; reads SHALL remain functional.
REQ-007 The FSM SHALL have states IDLE, REQ and DONE.
REQ-008 In IDLE, burst_start=1 SHALL latch burst_dir and burst_last, clear the index to 0 and enter REQ on the next edge.
REQ-009 burst_start while not in IDLE SHALL be ignored.
REQ-010 In REQ, mem_req=1, mem_we=~dir, mem_index=index, and mem_wdata=register[index].
REQ-011 In REQ with mem_ack=1 and dir=1, mem_rdata SHALL be written to register[index] on that edge.
REQ-012 In REQ with mem_ack=1: if index==last, go to DONE; otherwise increment index and stay in REQ; without mem_ack, hold all outputs.
REQ-013 In DONE, burst_done=1 for exactly one cycle, then return to IDLE.
REQ-014 burst_busy=1 in REQ and DONE.
REQ-015 burst_last=0 SHALL transfer exactly one register.
REQ-016 burst_last=NUM_REGS-1 SHALL include the flag register.
REQ-017 Index arithmetic SHALL be AW bits wide and never wraps, because termination occurs at last.
REQ-018 Minimum burst of N registers with mem_ack tied high: burst_start at cycle 0, requests in cycles 1..N, burst_done in cycle N+1.
REQ-019 In IDLE, mem_req, mem_we and burst_done SHALL be 0; mem_index=0; mem_wdata=register[0].

Reset
REQ-020 Asserting reset SHALL immediately force IDLE and clear index, latched dir and latched last to 0.
REQ-021 burst_busy, burst_done, mem_req and mem_we SHALL read 0 while reset is asserted, including mid-burst.
REQ-022 A burst interrupted by reset SHALL NOT resume; registers already loaded keep their new values.
REQ-023 Register contents on reset are governed by REQ-024.

Configuration
REQ-024 Macro CHIP8_REGFILE_RESET_CLEAR_EN defined: reset SHALL clear all NUM_REGS registers to 0, and readdata1, readdata2 and VFreaddata SHALL read 0 after reset.
REQ-025 Macro CHIP8_REGFILE_RESET_CLEAR_EN undefined: registers SHALL NOT be reset and retain contents across reset (RAM-inferable); only FSM and control state reset.

Verification
REQ-026 The bench SHALL cover:
  WE1=1 addr1=3 0x5A and WE2=1 addr2=3 0xA5 in the same cycle -> readdata1=0xA5 next cycle.
  WE2=1 addr2=15 0x11 and WEVF=1 0x01 in the same cycle -> VFreaddata=0x01.
  Store burst, last=2, mem_ack high, V0..V2=0x10,0x20,0x30 -> mem_wdata 0x10,0x20,0x30 in cycles 1-3, burst_done in cycle 4.
  Load burst, last=15, mem_ack stalled 2 cycles per request, mem_rdata=index+0x40 -> V0..VF=0x40..0x4F; WE1 pulses during the burst have no effect.
  Reset asserted in cycle 2 of a last=5 load -> mem_req=0 immediately; V0 loaded; V1..V5 unchanged (macro undefined) or all 0 (macro defined).
